// File: rtl/tri_scan_ring_ctl.sv
// Scan-ring access controller: stops the ring's functional clocks, shifts RING_LEN bits
// through ring_scin/ring_scout and returns the prior ring contents. Optional macro: TRI_SCAN_RING_PARITY_EN.
module tri_scan_ring_ctl #(
  parameter int RING_LEN   = 32,
  parameter int HOLD_CYC   = 2,
  parameter int NCLK_WIDTH = 6
) (
  input  logic [NCLK_WIDTH-1:0] nclk,
  inout  wire                   vd,
  inout  wire                   gd,
  input  logic                  req_val,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [RING_LEN-1:0]   req_wdata,
  output logic                  rsp_val,
  input  logic                  rsp_ack,
  output logic [RING_LEN-1:0]   rsp_rdata,
  output logic                  rsp_par,
  output logic                  thold_b,
  output logic                  sg,
  output logic                  ring_scin,
  input  logic                  ring_scout
);

  localparam int               CNT_W      = $clog2(RING_LEN + 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(RING_LEN - 1);
  localparam logic [CNT_W-1:0] SHIFT_SAT  = CNT_W'(RING_LEN);
  localparam logic [3:0]       HOLD_LAST  = 4'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOLD_ON  = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_HOLD_OFF = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  logic clk;
  logic rst;
  assign clk = nclk[0];
  assign rst = nclk[1];

  state_t              state_q,     state_d;
  logic [RING_LEN-1:0] shift_buf_q, shift_buf_d;
  logic                wr_q,        wr_d;
  logic [CNT_W-1:0]    shift_cnt_q, shift_cnt_d;
  logic [3:0]          hold_cnt_q,  hold_cnt_d;
  logic                req_rdy_q,   req_rdy_d;
  logic                rsp_val_q,   rsp_val_d;
  logic [RING_LEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                thold_b_q,   thold_b_d;
  logic                sg_q,        sg_d;
  logic                scin_q,      scin_d;
  logic                recirc_q,    recirc_d;
  logic                resp_load_s;

  // Power pins and the spare clock-bundle bits carry no logic.
  logic unused_pins_s;
  assign unused_pins_s = ^{vd, gd, nclk, resp_load_s};

  // Next-state and next-output computation for the shift sequence.
  always_comb begin
    state_d     = state_q;
    shift_buf_d = shift_buf_q;
    wr_d        = wr_q;
    shift_cnt_d = shift_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    req_rdy_d   = req_rdy_q;
    rsp_val_d   = rsp_val_q;
    rsp_rdata_d = rsp_rdata_q;
    thold_b_d   = thold_b_q;
    sg_d        = sg_q;
    scin_d      = 1'b0;
    recirc_d    = 1'b0;
    resp_load_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_val && req_rdy_q) begin
          state_d     = ST_HOLD_ON;
          shift_buf_d = req_wdata;
          wr_d        = req_wr;
          hold_cnt_d  = 4'd0;
          req_rdy_d   = 1'b0;
          thold_b_d   = 1'b0;
        end else begin
          req_rdy_d   = 1'b1;
        end
      end
      ST_HOLD_ON: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d     = ST_SHIFT;
          sg_d        = 1'b1;
          shift_cnt_d = {CNT_W{1'b0}};
          scin_d      = wr_q & shift_buf_q[0];
          recirc_d    = ~wr_q;
        end else begin
          hold_cnt_d  = hold_cnt_q + 4'd1;
        end
      end
      ST_SHIFT: begin
        // A read must hand scout straight back to scin in the same cycle, so it bypasses the scin flop.
        shift_buf_d = {ring_scout, shift_buf_q[RING_LEN-1:1]};
        shift_cnt_d = (shift_cnt_q == SHIFT_SAT) ? shift_cnt_q : shift_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (shift_cnt_q == SHIFT_LAST) begin
          state_d     = ST_HOLD_OFF;
          sg_d        = 1'b0;
          hold_cnt_d  = 4'd0;
        end else begin
          scin_d      = wr_q & shift_buf_q[1];
          recirc_d    = ~wr_q;
        end
      end
      ST_HOLD_OFF: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d     = ST_RESP;
          thold_b_d   = 1'b1;
          rsp_val_d   = 1'b1;
          rsp_rdata_d = shift_buf_q;
          resp_load_s = 1'b1;
        end else begin
          hold_cnt_d  = hold_cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ack) begin
          state_d     = ST_IDLE;
          rsp_val_d   = 1'b0;
          req_rdy_d   = 1'b1;
        end else begin
          rsp_val_d   = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_rdy_d   = 1'b1;
        rsp_val_d   = 1'b0;
        thold_b_d   = 1'b1;
        sg_d        = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset wins over every handshake input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_buf_q <= {RING_LEN{1'b0}};
      wr_q        <= 1'b0;
      shift_cnt_q <= {CNT_W{1'b0}};
      hold_cnt_q  <= 4'd0;
      req_rdy_q   <= 1'b1;
      rsp_val_q   <= 1'b0;
      rsp_rdata_q <= {RING_LEN{1'b0}};
      thold_b_q   <= 1'b1;
      sg_q        <= 1'b0;
      scin_q      <= 1'b0;
      recirc_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_buf_q <= shift_buf_d;
      wr_q        <= wr_d;
      shift_cnt_q <= shift_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      req_rdy_q   <= req_rdy_d;
      rsp_val_q   <= rsp_val_d;
      rsp_rdata_q <= rsp_rdata_d;
      thold_b_q   <= thold_b_d;
      sg_q        <= sg_d;
      scin_q      <= scin_d;
      recirc_q    <= recirc_d;
    end
  end

`ifdef TRI_SCAN_RING_PARITY_EN
  logic rsp_par_q, rsp_par_d;

  function automatic logic even_par(input logic [RING_LEN-1:0] data);
    return ^data;
  endfunction

  // Parity is captured together with rsp_rdata on RESP entry.
  always_comb begin
    if (resp_load_s) begin
      rsp_par_d = even_par(shift_buf_q);
    end else begin
      rsp_par_d = rsp_par_q;
    end
  end

  // Parity register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_par_q <= 1'b0;
    end else begin
      rsp_par_q <= rsp_par_d;
    end
  end

  assign rsp_par = rsp_par_q;
`else
  assign rsp_par = 1'b0;
`endif

  assign req_rdy   = req_rdy_q;
  assign rsp_val   = rsp_val_q;
  assign rsp_rdata = rsp_rdata_q;
  assign thold_b   = thold_b_q;
  assign sg        = sg_q;
  assign ring_scin = recirc_q ? ring_scout : scin_q;

endmodule

// File: tb/tb_tri_scan_ring_ctl.sv
// Bench for tri_scan_ring_ctl: 8-flop ring model, phase-based timing model checked every cycle,
// plus directed literal checks. Honours TRI_SCAN_RING_PARITY_EN.
module tb_tri_scan_ring_ctl;
  localparam int RL  = 8;
  localparam int H   = 2;
  localparam int LAT = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    nclk;
  wire           vd_w;
  wire           gd_w;
  logic          req_val = 1'b0;
  logic          req_wr = 1'b0;
  logic [RL-1:0] req_wdata = 8'h00;
  logic          rsp_ack = 1'b0;
  wire           req_rdy, rsp_val, rsp_par, thold_b, sg, ring_scin;
  wire  [RL-1:0] rsp_rdata;
  logic          ring_scout;

  assign nclk = {4'b0000, rst, clk};
  assign vd_w = 1'b1;
  assign gd_w = 1'b0;

  tri_scan_ring_ctl #(.RING_LEN(RL), .HOLD_CYC(H), .NCLK_WIDTH(6)) dut (
    .nclk(nclk), .vd(vd_w), .gd(gd_w),
    .req_val(req_val), .req_rdy(req_rdy), .req_wr(req_wr), .req_wdata(req_wdata),
    .rsp_val(rsp_val), .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata), .rsp_par(rsp_par),
    .thold_b(thold_b), .sg(sg), .ring_scin(ring_scin), .ring_scout(ring_scout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Ring model: ring_q[0] is the scout end; shifts while clocks stopped and in scan mode.
  logic [RL-1:0] ring_q;
  logic          ring_load = 1'b1;
  logic [RL-1:0] ring_load_val = 8'hA5;
  assign ring_scout = ring_q[0];

  always @(posedge clk) begin
    if (ring_load) ring_q <= ring_load_val;
    else if (thold_b === 1'b0 && sg === 1'b1) ring_q <= {ring_scin, ring_q[RL-1:1]};
  end

  // Transaction model: phases derived from elapsed cycles since accept.
  int            cyc = 0;
  int            m_acc = 0;
  logic          m_busy = 1'b0;
  logic          m_wr = 1'b0;
  logic [RL-1:0] m_wdata = 8'h00;
  logic [RL-1:0] m_rdata = 8'h00;
  logic [RL-1:0] m_ring = 8'h00;
  logic          ring_known = 1'b0;
  logic          chk_en = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ring_load) begin
      m_ring     <= ring_load_val;
      ring_known <= 1'b1;
    end
    if (rst) begin
      m_busy <= 1'b0;
      if (m_busy) ring_known <= 1'b0;
    end else if (!m_busy) begin
      if (req_val) begin
        m_busy  <= 1'b1;
        m_acc   <= cyc;
        m_wr    <= req_wr;
        m_wdata <= req_wdata;
        m_rdata <= m_ring;
        if (req_wr) m_ring <= req_wdata;
      end
    end else if ((cyc - m_acc) >= LAT && rsp_ack) begin
      m_busy <= 1'b0;
    end
  end

  function automatic void compare_cycle();
    int   e;
    logic e_val, e_sg, e_thold;
    e       = cyc - m_acc;
    e_thold = !(m_busy && e <= 2*H + RL);
    e_sg    = m_busy && e >= H + 1 && e <= H + RL;
    e_val   = m_busy && e >= 2*H + RL + 1;
    chk("req_rdy", req_rdy, !m_busy);
    chk("thold_b", thold_b, e_thold);
    chk("sg", sg, e_sg);
    chk("rsp_val", rsp_val, e_val);
    if (e_val) chk("rsp_rdata", rsp_rdata, m_rdata);
`ifdef TRI_SCAN_RING_PARITY_EN
    if (e_val) chk("rsp_par", rsp_par, ^m_rdata);
`else
    chk("rsp_par", rsp_par, 1'b0);
`endif
    if (e_sg) chk("ring_scin", ring_scin, m_wr ? m_wdata[e-H-1] : ring_scout);
    if (!m_busy && ring_known) chk("ring", ring_q, m_ring);
  endfunction

  always @(negedge clk) if (chk_en) compare_cycle();

  int   rise_cnt = 0;
  logic prev_val = 1'b0;
  always @(negedge clk) begin
    if (rsp_val === 1'b1 && prev_val !== 1'b1) rise_cnt <= rise_cnt + 1;
    prev_val <= rsp_val;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input logic wr, input logic [RL-1:0] wd, input int ack_dly,
                        output logic [RL-1:0] rd);
    int g;
    int lat;
    g = 0;
    while (req_rdy !== 1'b1 && g < 200) begin tick(); g++; end
    chk("rdy_wait", req_rdy, 1'b1);
    req_val = 1'b1; req_wr = wr; req_wdata = wd;
    tick();
    req_val = 1'b0;
    lat = 1;
    while (rsp_val !== 1'b1 && lat < 200) begin tick(); lat++; end
    chk("latency", lat, LAT);
    rd = rsp_rdata;
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      chk("hold_val", rsp_val, 1'b1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_thold", thold_b, 1'b1);
    end
    rsp_ack = 1'b1;
    tick();
    rsp_ack = 1'b0;
    chk("rdy_after_ack", req_rdy, 1'b1);
  endtask

  initial begin
    logic [RL-1:0] rd;
    int            r0;
    int            g;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; ring_load = 1'b0; chk_en = 1'b1;
    chk("rst_req_rdy", req_rdy, 1'b1);
    chk("rst_rsp_val", rsp_val, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_rsp_par", rsp_par, 1'b0);
    chk("rst_thold_b", thold_b, 1'b1);
    chk("rst_sg", sg, 1'b0);
    chk("rst_ring_scin", ring_scin, 1'b0);

    // Read of the preloaded ring, then write 0x3C and read it back.
    do_txn(1'b0, 8'h00, 0, rd);
    chk("read_a5", rd, 8'hA5);
    chk("ring_kept_a5", ring_q, 8'hA5);
    do_txn(1'b1, 8'h3C, 0, rd);
    chk("write_prior_a5", rd, 8'hA5);
    chk("ring_now_3c", ring_q, 8'h3C);
    do_txn(1'b0, 8'h00, 1, rd);
    chk("read_3c", rd, 8'h3C);

    // req_val held high through the whole busy period.
    r0 = rise_cnt;
    req_val = 1'b1; req_wr = 1'b0;
    tick();
    chk("busy_rdy_t1", req_rdy, 1'b0);
    g = 0;
    while (rsp_val !== 1'b1 && g < 200) begin
      chk("busy_rdy_low", req_rdy, 1'b0);
      tick(); g++;
    end
    chk("busy_resp", rsp_val, 1'b1);
    tick(); tick();
    chk("busy_rdy_in_resp", req_rdy, 1'b0);
    req_val = 1'b0; rsp_ack = 1'b1;
    tick();
    rsp_ack = 1'b0;
    chk("busy_rdy_after_ack", req_rdy, 1'b1);
    repeat (3) tick();
    chk("busy_one_txn", rise_cnt - r0, 1);

    // Reset in the middle of SHIFT (accept at T, reset sampled at the end of T+6).
    r0 = rise_cnt;
    req_val = 1'b1; req_wr = 1'b0;
    tick();
    req_val = 1'b0;
    repeat (5) tick();
    chk("mid_shift_sg", sg, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_thold_b", thold_b, 1'b1);
    chk("rst_mid_sg", sg, 1'b0);
    chk("rst_mid_req_rdy", req_rdy, 1'b1);
    chk("rst_mid_rsp_val", rsp_val, 1'b0);
    repeat (20) tick();
    chk("rst_no_resp", rise_cnt - r0, 0);
    ring_load = 1'b1; ring_load_val = 8'hA5;
    tick();
    ring_load = 1'b0;

    // Delayed acknowledge holds the response.
    do_txn(1'b0, 8'h00, 5, rd);
    chk("delayed_read_a5", rd, 8'hA5);

    // Parity patterns: 0xA5 (even) then 0xA4 (odd).
    do_txn(1'b1, 8'hA4, 0, rd);
    chk("write_prior_a5_2", rd, 8'hA5);
    g = 0;
    while (req_rdy !== 1'b1 && g < 200) begin tick(); g++; end
    req_val = 1'b1; req_wr = 1'b0;
    tick();
    req_val = 1'b0;
    g = 1;
    while (rsp_val !== 1'b1 && g < 200) begin tick(); g++; end
    chk("read_a4", rsp_rdata, 8'hA4);
`ifdef TRI_SCAN_RING_PARITY_EN
    chk("par_a4", rsp_par, 1'b1);
`else
    chk("par_off_a4", rsp_par, 1'b0);
`endif
    rsp_ack = 1'b1;
    tick();
    rsp_ack = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tri_scan_ring_ctl.md
# tri_scan_ring_ctl

Scan-ring access controller: the shifting master at the far end of the `scin`/`scout` chain formed by the scannable `tri_` latches. It accepts a parallel read or write request, stops the ring's functional clocks, serially shifts `RING_LEN` bits through the ring, restores functional mode and returns the captured ring contents. It sits beside the pervasive logic of a unit and drives the `thold_b`/`sg` inputs of that unit's latch LCBs.

## Interface
Parameters:
- `RING_LEN`, 32, number of latches in the ring; legal range 2..1024.
- `HOLD_CYC`, 2, settle cycles around the shift window; legal range 1..15.

Ports:
- `nclk`  in  `NCLK_WIDTH`  clock bundle; `nclk[0]` is the clock. `nclk[1]` is the synchronous active-high reset; remaining bits are unused.
- `vd`, `gd`  inout  1  power/ground; unreferenced.
- `req_val`  in  1  request valid.
- `req_rdy`  out  1  controller idle, request accepted when `req_val & req_rdy`.
- `req_wr`  in  1  1 = write `req_wdata` into ring; 0 = read-only (ring contents preserved).
- `req_wdata`  in  `RING_LEN`  write data; bit 0 shifted first.
- `rsp_val`  out  1  response valid; held until acked.
- `rsp_ack`  in  1  response consumed.
- `rsp_rdata`  out  `RING_LEN`  prior ring contents; bit i = i-th bit emerging from `ring_scout`.
- `rsp_par`  out  1  even parity of `rsp_rdata` (see Configuration).
- `thold_b`  out  1  to ring LCBs; 0 stops functional clocking.
- `sg`  out  1  to ring LCBs; 1 = scan mode.
- `ring_scin`  out  1  serial data into ring.
- `ring_scout`  in  1  serial data out of ring.

## Operation
- All outputs registered. Reset values: `req_rdy`=1, `rsp_val`=0, `rsp_rdata`=0, `rsp_par`=0, `thold_b`=1, `sg`=0, `ring_scin`=0; state IDLE.
- States: IDLE, HOLD_ON, SHIFT, HOLD_OFF, RESP.
- IDLE: `req_rdy`=1. On accept, latch `req_wr` and `req_wdata` into shift buffer `buf`, and go to HOLD_ON.
- HOLD_ON: `thold_b`=0, `sg`=0, for `HOLD_CYC` cycles, then SHIFT.
- SHIFT: `thold_b`=0, `sg`=1, for exactly `RING_LEN` cycles.
  - Each cycle, the write case drives `ring_scin`=`buf[0]`; the read case drives `ring_scin`=`ring_scout` (recirculate).
  - Each cycle, `buf` <= {`buf[1:RING_LEN-1]`, `ring_scout`}.
- HOLD_OFF: `sg`=0, `thold_b`=0, for `HOLD_CYC` cycles, then RESP.
- RESP: `thold_b`=1, `rsp_val`=1, `rsp_rdata`=`buf`. On `rsp_ack`, go to IDLE next cycle.
- `req_val` outside IDLE is ignored; no queuing.
- `sg` and `thold_b` never change in the same cycle. `sg`=1 only while `thold_b`=0.
- The shift counter is sized as ceil(log2(`RING_LEN`+1)) and saturates at no value other than `RING_LEN`.
- Synchronous reset in any state: next cycle is IDLE with reset output values. No response is issued. Ring contents are undefined (partially shifted), and reissuing the request is the requester's job.
- Reset has priority over all handshake inputs in the same cycle.

## Timing
- Accept at cycle T.
- HOLD_ON covers T+1..T+`HOLD_CYC`.
- SHIFT covers T+`HOLD_CYC`+1..T+`HOLD_CYC`+`RING_LEN`.
- HOLD_OFF covers the next `HOLD_CYC` cycles.
- `rsp_val` rises at T+2·`HOLD_CYC`+`RING_LEN`+1.
- `rsp_ack` sampled high with `rsp_val` gives `req_rdy`=1 on the following cycle, so the minimum request-to-request interval is 2·`HOLD_CYC`+`RING_LEN`+2 cycles.
- `rsp_rdata` and `rsp_par` are stable while `rsp_val`=1.
- `ring_scout` is sampled on the same edge that the ring latches capture `ring_scin` (single-cycle ring hop).

## Configuration
- `TRI_SCAN_RING_PARITY_EN` defined: `rsp_par` = XOR of all bits of `buf`, registered with `rsp_rdata` at RESP entry.
- Not defined: `rsp_par` is tied 0 and no parity logic is built.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use `RING_LEN`=8, `HOLD_CYC`=2, and a bench model of an 8-flop ring clocked when `thold_b`=0 & `sg`=1 and preloaded with 0xA5 (scout-end first).
- Read (`req_wr`=0) accepted at T -> `rsp_val` at T+13, `rsp_rdata`=0xA5 in emergence order, and the ring still holds 0xA5.
- Write 0x3C at T, then a read -> the read returns 0x3C; the write's `rsp_rdata` returns the prior 0xA5.
- `req_val` held high through a busy period -> `req_rdy`=0 from T+1 until the cycle after `rsp_ack`, and exactly one transaction is performed.
- Reset asserted at T+6 (mid-SHIFT) -> next cycle `thold_b`=1, `sg`=0, `req_rdy`=1, no `rsp_val`.
- `rsp_ack` delayed 5 cycles -> `rsp_val`/`rsp_rdata` held, `thold_b`=1 throughout.
- With `TRI_SCAN_RING_PARITY_EN`: a read of 0xA5 gives `rsp_par`=0, and a read of 0xA4 gives `rsp_par`=1. Without the macro, `rsp_par`=0 always.
